// File: rtl/master_out_port.sv
// master_out_port: serializes a host read/write request onto a 1-bit address/data/burst bus.
// Ports: clk/reset (async, active-high); req_* host request (req_ready high in IDLE);
//        wdata/wdata_valid/wdata_ready burst write bytes; master_valid/slave_ready bus handshake;
//        read_en/write_en transaction type; tx_address/tx_data/tx_burst serial lines, LSB first;
//        tx_done end-of-transaction pulse; underflow sticky missing-wdata flag.
module master_out_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [11:0] req_addr,
    input  logic [7:0]  req_data,
    input  logic [11:0] req_burst,
    input  logic [7:0]  wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic        master_valid,
    input  logic        slave_ready,
    output logic        read_en,
    output logic        write_en,
    output logic        tx_address,
    output logic        tx_data,
    output logic        tx_burst,
    output logic        tx_done,
    output logic        underflow
);
    typedef enum logic [2:0] {IDLE, WAIT_HS, ADDR_TX, BURST_TX, BEAT, DONE} state_t;
    state_t      state, state_n;
    logic [11:0] addr_q, beat, beat_n;
    logic [7:0]  data_q, wbyte;
    logic [12:0] f_q;
    logic [3:0]  cyc, cyc_n;
    logic        write_q, hs, last, slot_start, active;
    always_comb begin
        hs         = state == WAIT_HS && slave_ready;
        last       = cyc == 4'd11;
        // BURST_TX is both the cycle carrying F[12] and the first cycle of beat 1
        slot_start = state == BURST_TX || (state == BEAT && cyc == 4'd0);
        active     = state inside {WAIT_HS, ADDR_TX, BURST_TX, BEAT};
        state_n    = state;
        case (state)
            IDLE:     state_n = req_valid ? WAIT_HS : IDLE;
            WAIT_HS:  state_n = slave_ready ? ADDR_TX : WAIT_HS;
            ADDR_TX:  state_n = !last ? ADDR_TX : f_q[0] ? BURST_TX : DONE;
            BURST_TX: state_n = BEAT;
            BEAT:     state_n = last && beat == f_q[12:1] ? DONE : BEAT;
            default:  state_n = IDLE;
        endcase
        cyc_n  = (state == WAIT_HS || state == BURST_TX) ? 4'd1 :
                 (state == ADDR_TX || state == BEAT) && !last ? cyc + 4'd1 : 4'd0;
        // beat stops at N so N = 4095 never wraps
        beat_n = state == ADDR_TX && last ? 12'd1 :
                 state == BEAT && last && state_n == BEAT ? beat + 12'd1 :
                 state == IDLE ? 12'd0 : beat;
        req_ready    = state == IDLE;
        master_valid = state == WAIT_HS;
        read_en      = active && !write_q;
        write_en     = active && write_q;
        tx_done      = state == DONE;
        wdata_ready  = slot_start && write_q && wdata_valid;
        tx_address   = hs ? addr_q[0] : state == ADDR_TX && addr_q[cyc];
        tx_burst     = hs ? f_q[0] : state == ADDR_TX ? f_q[cyc] : state == BURST_TX && f_q[12];
        // slot start uses wdata directly since the byte is only latched at the end of that cycle
        tx_data      = write_q && (hs ? data_q[0] :
                       state == ADDR_TX ? cyc < 4'd8 && data_q[cyc[2:0]] :
                       slot_start ? wdata_valid && wdata[0] :
                       state == BEAT && cyc < 4'd8 && wbyte[cyc[2:0]]);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            f_q       <= '0;
            cyc       <= '0;
            beat      <= '0;
            wbyte     <= '0;
            underflow <= 1'b0;
        end else begin
            state <= state_n;
            cyc   <= cyc_n;
            beat  <= beat_n;
            if (req_valid && req_ready) begin
                addr_q  <= req_addr;
                data_q  <= req_data;
                write_q <= req_write;
                f_q     <= {req_burst, req_burst != 12'd0};
            end
            if (slot_start)
                wbyte <= wdata_valid ? wdata : 8'h00;
            if (slot_start && write_q && !wdata_valid)
                underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_master_out_port.sv
// tb_master_out_port: scoreboard bench for master_out_port with directed transactions.
module tb_master_out_port;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, wdata_valid = 1'b0, slave_ready = 1'b0;
    logic [11:0] req_addr = '0, req_burst = '0;
    logic [7:0]  req_data = '0, wdata = '0;
    logic        req_ready, wdata_ready, master_valid, read_en, write_en;
    logic        tx_address, tx_data, tx_burst, tx_done, underflow;

    master_out_port dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data), .req_burst(req_burst),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .master_valid(master_valid), .slave_ready(slave_ready), .read_en(read_en),
        .write_en(write_en), .tx_address(tx_address), .tx_data(tx_data), .tx_burst(tx_burst),
        .tx_done(tx_done), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic [11:0] n;
        logic [23:0] bytes;
        logic [2:0]  mask;
        logic [7:0]  wt;
        logic        uf;
        logic        abort;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0, n_fail = 0, mv_len = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_txn();
        exp_t        e;
        logic [12:0] f, bst;
        logic [11:0] ag;
        logic [7:0]  bg [4];
        int          total, slot, sc, pulses, exp_pulses, done_at;
        bit          bad_en, bad_mv, bad_a, bad_b, bad_d, bad_wp, aborted;
        logic        uf_done;
        if (q.size() == 0) begin
            check("unexpected_txn", 0, 1);
            return;
        end
        e = q.pop_front();
        check("mv_len", mv_len, 32'(e.wt) + 1);
        f = {e.n, e.n != 12'd0};
        total = 12 * (int'(e.n) + 1);
        ag = '0; bst = '0;
        foreach (bg[i]) bg[i] = '0;
        pulses = 0; done_at = -1; uf_done = 1'bx;
        {bad_en, bad_mv, bad_a, bad_b, bad_d, bad_wp, aborted} = '0;
        for (int c = 0; c <= total + 2; c++) begin
            if (c > 0) @(negedge clk);
            if (reset) begin
                aborted = 1'b1;
                check("abort_outs", {master_valid, read_en, write_en, tx_address, tx_data,
                                     tx_burst, wdata_ready, tx_done, underflow}, 0);
                check("abort_ready", req_ready, 1);
                break;
            end
            if (tx_done) begin
                done_at = c;
                uf_done = underflow;
                check("done_en", {read_en, write_en}, 0);
                break;
            end
            if ({read_en, write_en} != {~e.wr, e.wr}) bad_en = 1'b1;
            if (c > 0 && master_valid) bad_mv = 1'b1;
            if (c < 12) ag[c] = tx_address; else if (tx_address) bad_a = 1'b1;
            if (c < 13) bst[c] = tx_burst; else if (tx_burst) bad_b = 1'b1;
            slot = c / 12;
            sc = c % 12;
            if (sc < 8 && slot < 4) bg[slot][sc] = tx_data; else if (tx_data) bad_d = 1'b1;
            if (wdata_ready) begin
                pulses++;
                if (sc != 0 || c == 0) bad_wp = 1'b1;
            end
        end
        if (e.abort) begin
            check("abort_seen", aborted, 1);
            return;
        end
        check("no_abort", aborted, 0);
        check("addr", ag, e.addr);
        check("burst", bst, f);
        exp_pulses = 0;
        for (int k = 0; k <= int'(e.n) && k < 4; k++) begin
            if (k == 0)
                check("byte0", bg[0], e.wr ? e.data : 8'h00);
            else begin
                check($sformatf("byte%0d", k), bg[k], (e.wr && e.mask[k-1]) ? e.bytes[8*(k-1) +: 8] : 8'h00);
                if (e.wr && e.mask[k-1]) exp_pulses++;
            end
        end
        check("wr_pulses", pulses, exp_pulses);
        check("en_held", bad_en, 0);
        check("mv_drop", bad_mv, 0);
        check("addr_zero", bad_a, 0);
        check("burst_zero", bad_b, 0);
        check("data_zero", bad_d, 0);
        check("wr_pos", bad_wp, 0);
        check("done_at", done_at, total);
        check("underflow", uf_done, e.uf);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) mv_len = 0;
            else begin
                if (master_valid) mv_len++;
                if (master_valid && slave_ready) begin
                    check_txn();
                    mv_len = 0;
                end else
                    check("stray_done", tx_done, 0);
            end
        end
    end

    task automatic run(input logic [11:0] a, input logic [7:0] d, input logic wr, input logic [11:0] n,
                       input logic [23:0] bytes, input logic [2:0] mask, input int wt,
                       input logic uf, input logic hold, input int abort_at);
        exp_t e;
        int   g, total, k;
        e.addr = a; e.data = d; e.wr = wr; e.n = n; e.bytes = bytes; e.mask = mask;
        e.wt = 8'(wt); e.uf = uf; e.abort = abort_at > 0;
        q.push_back(e);
        req_addr = a; req_data = d; req_write = wr; req_burst = n; req_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 100) begin
            g++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("accept", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = hold;
        slave_ready = 1'b0;
        for (int i = 0; i < wt; i++) begin
            @(posedge clk); #1;
            if (hold) req_addr = req_addr + 12'h111;
        end
        slave_ready = 1'b1;
        total = 12 * (int'(n) + 1);
        for (int c = 1; c <= total; c++) begin
            @(posedge clk); #1;
            if (c == 1) slave_ready = 1'b0;
            if (hold) begin
                req_addr = req_addr + 12'h111;
                req_data = ~req_data;
                req_write = ~req_write;
                req_burst = req_burst + 12'd1;
            end
            if (c == abort_at) begin
                reset = 1'b1;
                req_valid = 1'b0;
                wdata_valid = 1'b0;
                @(posedge clk);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            wdata_valid = 1'b0;
            if (c % 12 == 0 && c < total) begin
                k = c / 12;
                if (k <= 3) begin
                    wdata = bytes[8*(k-1) +: 8];
                    wdata_valid = mask[k-1];
                end
            end
        end
        wdata_valid = 1'b0;
        req_valid = hold;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_outs", {master_valid, read_en, write_en, tx_address, tx_data, tx_burst,
                           wdata_ready, tx_done, underflow}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run(12'hA5C, 8'h3B, 1'b1, 12'd0, 24'h0, 3'b000, 0, 1'b0, 1'b0, 0);
        run(12'h001, 8'hFF, 1'b0, 12'd0, 24'h0, 3'b000, 5, 1'b0, 1'b0, 0);
        run(12'h3C7, 8'h96, 1'b1, 12'd2, 24'h002211, 3'b011, 0, 1'b0, 1'b0, 0);
        run(12'h5E1, 8'hC4, 1'b0, 12'd1, 24'h0000FF, 3'b001, 2, 1'b0, 1'b0, 0);
        run(12'h7F0, 8'h81, 1'b1, 12'd0, 24'h0, 3'b000, 1, 1'b0, 1'b1, 0);
        run(12'h123, 8'h45, 1'b1, 12'd0, 24'h0, 3'b000, 0, 1'b0, 1'b0, 0);
        run(12'hFFF, 8'hA7, 1'b1, 12'd1, 24'h0, 3'b000, 0, 1'b1, 1'b0, 0);
        run(12'h0F0, 8'h5A, 1'b1, 12'd3, 24'hC3003C, 3'b101, 0, 1'b1, 1'b0, 0);
        run(12'h456, 8'h78, 1'b1, 12'd0, 24'h0, 3'b000, 0, 1'b0, 1'b0, 5);
        run(12'h9AB, 8'hCD, 1'b1, 12'd0, 24'h0, 3'b000, 0, 1'b0, 1'b0, 0);
        run(12'h800, 8'h00, 1'b0, 12'hFFF, 24'h0, 3'b000, 0, 1'b0, 1'b0, 0);
        repeat (5) @(posedge clk);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/master_out_port.md
MASTER_OUT_PORT -- requirements
Module: master_out_port

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  host request strobe
- req_ready  out  1  high in IDLE only; request accepted when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  12  start address
- req_data  in  8  first write byte
- req_burst  in  12  extra beats N; 0 = single transfer
- wdata  in  8  next write byte for burst beats
- wdata_valid  in  1  wdata present
- wdata_ready  out  1  one-cycle pulse when wdata is consumed
- master_valid  out  1  bus valid to slave
- slave_ready  in  1  slave ready
- read_en, write_en  out  1 each  transaction type, held for the whole transaction
- tx_address, tx_data, tx_burst  out  1 each  serial lines, LSB first
- tx_done  out  1  one-cycle pulse after the final beat
- underflow  out  1  sticky; wdata was missing at a beat start
REQ-002 SHALL use clock clk and reset reset, asynchronous, active-high; all state SHALL update on the rising edge of clk.

Function
REQ-003 SHALL implement states IDLE, WAIT_HS, ADDR_TX, BURST_TX, BEAT, DONE.
REQ-004 On acceptance in IDLE, the block SHALL latch addr/data/write/burst into shadow registers and move to WAIT_HS on the next cycle; the burst shadow is F = {req_burst, (req_burst != 0)}, 13 bits.
REQ-005 In WAIT_HS: master_valid = 1; read_en = ~write and write_en = write. The block SHALL stay in WAIT_HS for any number of cycles while slave_ready = 0.
REQ-006 Handshake cycle (cycle 0) = master_valid & slave_ready. In cycle 0 the lines SHALL carry:
- tx_address = addr[0]
- tx_data = data[0] if write, else 0
- tx_burst = F[0]
REQ-007 master_valid SHALL drop to 0 in cycle 1.
REQ-008 In cycles 1..11 tx_address SHALL carry addr[1..11]. For writes, tx_data SHALL carry data[1..7] in cycles 1..7 and 0 otherwise.
REQ-009 If F[0] = 1, tx_burst SHALL carry F[1..12] in cycles 1..12 (BURST_TX covers cycle 12). Otherwise tx_burst SHALL be 0 after cycle 0.
REQ-010 Beat 0 occupies cycles 0..11. Beat k (1..N) occupies the 12-cycle slot starting at cycle 12k in state BEAT. The address lines SHALL stay 0 during BEAT; the slave increments the address itself.
REQ-011 Write burst, at the start of each slot k ≥ 1:
- if wdata_valid = 1, the block SHALL latch wdata, pulse wdata_ready, and shift the byte on tx_data LSB first over slot cycles 0..7;
- if wdata_valid = 0, the block SHALL send 0x00 and set underflow.
REQ-012 Read bursts SHALL drive tx_data = 0 throughout and never pulse wdata_ready.
REQ-013 The beat counter SHALL be 12 bits and SHALL reach exactly N with no wrap; N = 4095 yields 4096 beats.
REQ-014 After the last slot cycle, the block SHALL enter DONE for one cycle: tx_done = 1, read_en = write_en = 0. It SHALL then return to IDLE with req_ready = 1.
REQ-015 req_valid SHALL be ignored outside IDLE. A request asserted in the DONE cycle SHALL be accepted in the following IDLE cycle.
REQ-016 Shadow registers SHALL NOT change between acceptance and DONE, regardless of any change on the req_* inputs.
REQ-017 underflow SHALL clear only on reset.

Reset
REQ-018 While reset = 1, the block SHALL be in IDLE with req_ready = 1 and every other output 0: master_valid, read_en, write_en, tx_*, wdata_ready, tx_done, underflow. Shadow registers and counters SHALL be 0.
REQ-019 Reset mid-transaction SHALL abort immediately with no tx_done. The block SHALL accept a new request on the first edge after reset deasserts.

Verification
REQ-020 Single write, addr 0xA5C, data 0x3B, N = 0, slave_ready = 1 -> tx_address bits 0,0,1,1,1,0,1,0,0,1,0,1 in cycles 0..11; tx_data 1,1,0,1,1,1,0,0 in cycles 0..7; tx_burst 0; tx_done in cycle 12.
REQ-021 Read, addr 0x001, slave_ready low for 5 cycles -> master_valid high for 6 cycles; write_en = 0 and read_en = 1 throughout; tx_data always 0.
REQ-022 Write burst, N = 2, wdata 0x11 then 0x22 presented -> tx_burst = F = 0x005 over cycles 0..12; wdata_ready pulses at cycles 12 and 24; tx_done at cycle 36.
REQ-023 Write burst, N = 1, wdata_valid = 0 -> slot 1 sends 0x00; underflow = 1 and stays set after tx_done.
REQ-024 Reset asserted at cycle 5 of a write -> all outputs 0 in the same cycle; no tx_done; the next request completes correctly.
REQ-025 req_valid held high with changing req_addr during a transaction -> serialized address equals the accepted value; the second request starts in the IDLE cycle after DONE.
